// File: rtl/mat_mul_pkg.sv
// Shared constants and state encoding for the mat_mul front-end and the mat_mul core.
// Matrix-size constants are derived from DIM_LOG so both sides agree on N*N.
package mat_mul_pkg;

    localparam int unsigned MM_DIM_LOG = 1;
    localparam int unsigned NN         = 1 << (2 * MM_DIM_LOG);
    localparam int unsigned CNT_W      = 2 * MM_DIM_LOG;

    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        GAP      = 3'd1,
        LOAD_B   = 3'd2,
        START    = 3'd3,
        WAIT_RES = 3'd4
    } mm_state_e;

    // Words per matrix for a given log2 dimension.
    function automatic int unsigned nn_of(input int unsigned dim_log);
        return 32'd1 << (32'd2 * dim_log);
    endfunction

    // Width of a counter that indexes every word of one matrix.
    function automatic int unsigned cnt_w_of(input int unsigned dim_log);
        return 32'd2 * dim_log;
    endfunction

endpackage

// File: rtl/mat_stream_sequencer.sv
// Splits one DMA job packet (A then B) into two tlast-terminated matrix transfers for mat_mul,
// pulses start once both are loaded and holds the next job until the result stream ends.
module mat_stream_sequencer
    import mat_mul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIM_LOG    = MM_DIM_LOG
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  mm_sel,
    output logic                  mm_start,
    input  logic                  res_tvalid,
    input  logic                  res_tready,
    input  logic                  res_tlast,
    input  logic                  err_clr,
    output logic                  busy,
    output logic                  err_len
);

    localparam int unsigned JOB_NN    = nn_of(DIM_LOG);
    localparam int unsigned JOB_CNT_W = cnt_w_of(DIM_LOG);

    localparam logic [JOB_CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [JOB_CNT_W-1:0] CNT_ONE  = JOB_CNT_W'(1);
    localparam logic [JOB_CNT_W-1:0] CNT_LAST = JOB_CNT_W'(JOB_NN - 1);

    mm_state_e              state_q, state_d;
    logic [JOB_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   err_len_q, err_len_d;

    logic in_load_s;
    logic beat_s;
    logic cnt_last_s;
    logic set_err_s;
    logic res_done_s;

    // Stream pass-through; gated by reset so the reset cycle itself shows idle handshakes.
    always_comb begin
        in_load_s     = (state_q == LOAD_A) || (state_q == LOAD_B);
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = in_load_s & s_axis_tvalid & ~s00_axi_areset;
        s_axis_tready = in_load_s & m_axis_tready & ~s00_axi_areset;
        cnt_last_s    = (cnt_q == CNT_LAST);
        m_axis_tlast  = (cnt_last_s | s_axis_tlast) & ~s00_axi_areset;
        beat_s        = s_axis_tvalid & s_axis_tready;
        res_done_s    = res_tvalid & res_tready & res_tlast;
    end

    // State, beat counter and sticky length-error registers.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state_q   <= LOAD_A;
            cnt_q     <= CNT_ZERO;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_len_q <= err_len_d;
        end
    end

    // Next-state, counter and error-set logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        set_err_s = 1'b0;
        case (state_q)
            LOAD_A: begin
                // A tlast inside matrix A always means the packet ended too early.
                if (beat_s) begin
                    if (s_axis_tlast) begin
                        set_err_s = 1'b1;
                        state_d   = LOAD_A;
                        cnt_d     = CNT_ZERO;
                    end else if (cnt_last_s) begin
                        state_d = GAP;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            GAP: begin
                state_d = LOAD_B;
            end
            LOAD_B: begin
                if (beat_s) begin
                    if (cnt_last_s) begin
                        set_err_s = ~s_axis_tlast;
                        state_d   = START;
                        cnt_d     = CNT_ZERO;
                    end else if (s_axis_tlast) begin
                        set_err_s = 1'b1;
                        state_d   = LOAD_A;
                        cnt_d     = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            START: begin
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_done_s) begin
                    state_d = LOAD_A;
                end else begin
                    state_d = WAIT_RES;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // A new error in the same cycle as a clear request must survive.
        if (set_err_s) begin
            err_len_d = 1'b1;
        end else if (err_clr) begin
            err_len_d = 1'b0;
        end else begin
            err_len_d = err_len_q;
        end
    end

    // Control outputs decoded from the registered state.
    always_comb begin
        mm_sel   = 1'b0;
        mm_start = 1'b0;
        case (state_q)
            LOAD_A:   mm_sel = 1'b0;
            GAP:      mm_sel = 1'b1;
            LOAD_B:   mm_sel = 1'b1;
            START: begin
                mm_sel   = 1'b1;
                mm_start = 1'b1;
            end
            WAIT_RES: mm_sel = 1'b1;
            default:  mm_sel = 1'b0;
        endcase
        busy    = (state_q != LOAD_A) || (cnt_q != CNT_ZERO);
        err_len = err_len_q;
    end

endmodule

// File: tb/tb_mat_stream_sequencer.sv
// Directed bench for mat_stream_sequencer with DIM_LOG=1 (NN=4, 8-word jobs).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mat_stream_sequencer;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        mm_sel;
    logic        mm_start;
    logic        res_tvalid = 1'b0;
    logic        res_tready = 1'b0;
    logic        res_tlast = 1'b0;
    logic        err_clr = 1'b0;
    logic        busy;
    logic        err_len;

    int n_checks = 0;
    int n_fail   = 0;
    logic toggle_mode = 1'b0;
    logic tog_phase   = 1'b1;

    always #5 clk = ~clk;

    mat_stream_sequencer #(.DATA_WIDTH(32), .DIM_LOG(1)) dut (
        .s00_axi_aclk  (clk),
        .s00_axi_areset(areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .mm_sel        (mm_sel),
        .mm_start      (mm_start),
        .res_tvalid    (res_tvalid),
        .res_tready    (res_tready),
        .res_tlast     (res_tlast),
        .err_clr       (err_clr),
        .busy          (busy),
        .err_len       (err_len)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offer one beat and wait (bounded) for the handshake; reports cycles spent waiting.
    task automatic send_beat(input logic [31:0] d, input logic last, input logic exp_sel,
                             input logic exp_mlast, input logic gap_first, output int waits);
        logic done;
        waits = 0;
        done  = 1'b0;
        @(negedge clk);
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        for (int p = 0; p < 20 && !done; p++) begin
            if (toggle_mode) begin
                m_tready  = tog_phase;
                tog_phase = ~tog_phase;
            end
            #1;
            check_val("s_tready", {31'd0, s_tready},
                      (gap_first && p == 0) ? 32'd0 : {31'd0, m_tready});
            if (s_tready) begin
                check_val("m_tdata", m_tdata, d);
                check_val("m_tvalid", {31'd0, m_tvalid}, 32'd1);
                check_val("m_tlast", {31'd0, m_tlast}, {31'd0, exp_mlast});
                check_val("mm_sel", {31'd0, mm_sel}, {31'd0, exp_sel});
                done = 1'b1;
                @(posedge clk);
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        if (!done) check_val("beat_timeout", 32'd0, 32'd1);
    endtask

    // Send words first..last_word; tlast on word tl_at (0 = never).
    task automatic send_packet(input int first, input int last_word, input int tl_at);
        int w;
        logic lst;
        for (int i = first; i <= last_word; i++) begin
            lst = (i == tl_at);
            send_beat(i, lst, (i > 4), (i == 4) || (i == 8) || lst, (i == 5), w);
            if (!toggle_mode) check_val("wait_cycles", w, (i == 5) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
    endtask

    // Called at negedge+1 of the START cycle; checks the pulse then drains the result stream.
    task automatic check_start_and_result();
        check_val("start_pulse", {31'd0, mm_start}, 32'd1);
        check_val("start_busy", {31'd0, busy}, 32'd1);
        check_val("start_rdy", {31'd0, s_tready}, 32'd0);
        check_val("start_sel", {31'd0, mm_sel}, 32'd1);
        @(negedge clk); #1;
        check_val("start_gone", {31'd0, mm_start}, 32'd0);
        check_val("wait_busy", {31'd0, busy}, 32'd1);
        check_val("wait_rdy", {31'd0, s_tready}, 32'd0);
        // tlast without consumer ready is not a result handshake
        res_tvalid = 1'b1; res_tready = 1'b0; res_tlast = 1'b1;
        @(negedge clk); #1;
        check_val("res_noready", {31'd0, busy}, 32'd1);
        res_tready = 1'b1; res_tlast = 1'b0;
        @(negedge clk); #1;
        check_val("res_midbeat", {31'd0, busy}, 32'd1);
        res_tlast = 1'b1;
        @(negedge clk);
        res_tvalid = 1'b0; res_tready = 1'b0; res_tlast = 1'b0;
        #1;
        check_val("done_busy", {31'd0, busy}, 32'd0);
        check_val("done_sel", {31'd0, mm_sel}, 32'd0);
        check_val("done_rdy", {31'd0, s_tready}, 32'd1);
    endtask

    initial begin
        // Reset state, with inputs trying to look active
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_val("rst_tready", {31'd0, s_tready}, 32'd0);
        check_val("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
        check_val("rst_mlast", {31'd0, m_tlast}, 32'd0);
        check_val("rst_sel", {31'd0, mm_sel}, 32'd0);
        check_val("rst_start", {31'd0, mm_start}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_err", {31'd0, err_len}, 32'd0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
        areset = 1'b0;

        // 1: good packet
        send_packet(1, 8, 8);
        check_val("t1_err", {31'd0, err_len}, 32'd0);
        check_start_and_result();

        // 2: downstream ready toggling
        toggle_mode = 1'b1;
        tog_phase   = 1'b1;
        send_packet(1, 8, 8);
        toggle_mode = 1'b0;
        m_tready    = 1'b1;
        #0;
        check_start_and_result();

        // 3: early tlast on word 6
        send_packet(1, 6, 6);
        check_val("t3_err", {31'd0, err_len}, 32'd1);
        check_val("t3_start", {31'd0, mm_start}, 32'd0);
        check_val("t3_busy", {31'd0, busy}, 32'd0);
        check_val("t3_sel", {31'd0, mm_sel}, 32'd0);
        send_packet(1, 8, 8);
        check_start_and_result();
        check_val("t3_err_sticky", {31'd0, err_len}, 32'd1);

        // Clear err_len before the next error case
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check_val("clr1", {31'd0, err_len}, 32'd0);

        // 4: tlast missing; err_clr held on the erroring beat so set must win
        send_packet(1, 7, 0);
        err_clr = 1'b1;
        send_packet(8, 8, 0);
        err_clr = 1'b0;
        check_val("t4_set_wins", {31'd0, err_len}, 32'd1);
        check_start_and_result();
        @(negedge clk);
        err_clr = 1'b1;
        #1;
        check_val("t4_before_clr", {31'd0, err_len}, 32'd1);
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check_val("t4_cleared", {31'd0, err_len}, 32'd0);

        // 5: reset in the middle of matrix B
        send_packet(1, 6, 0);
        check_val("t5_busy_pre", {31'd0, busy}, 32'd1);
        areset = 1'b1;
        @(negedge clk); #1;
        check_val("t5_tready", {31'd0, s_tready}, 32'd0);
        check_val("t5_mvalid", {31'd0, m_tvalid}, 32'd0);
        check_val("t5_sel", {31'd0, mm_sel}, 32'd0);
        check_val("t5_start", {31'd0, mm_start}, 32'd0);
        check_val("t5_busy", {31'd0, busy}, 32'd0);
        areset = 1'b0;
        #1;
        check_val("t5_post_rdy", {31'd0, s_tready}, 32'd1);
        check_val("t5_post_busy", {31'd0, busy}, 32'd0);
        send_packet(1, 8, 8);
        check_start_and_result();

        // 6: next job offered while waiting for the result
        send_packet(1, 8, 8);
        check_val("t6_start", {31'd0, mm_start}, 32'd1);
        s_tdata  = 32'd1;
        s_tvalid = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            check_val("t6_held_rdy", {31'd0, s_tready}, 32'd0);
            check_val("t6_held_mvalid", {31'd0, m_tvalid}, 32'd0);
        end
        res_tvalid = 1'b1; res_tready = 1'b1; res_tlast = 1'b1;
        #1;
        check_val("t6_res_cycle_rdy", {31'd0, s_tready}, 32'd0);
        @(negedge clk);
        res_tvalid = 1'b0; res_tready = 1'b0; res_tlast = 1'b0;
        #1;
        check_val("t6_accept_rdy", {31'd0, s_tready}, 32'd1);
        check_val("t6_accept_sel", {31'd0, mm_sel}, 32'd0);
        check_val("t6_accept_data", m_tdata, 32'd1);
        @(posedge clk);
        send_packet(2, 8, 8);
        check_start_and_result();
        check_val("final_err", {31'd0, err_len}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
